// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registers decoded fields from ID, forwards results
// from MEM/WB into the ALU operands, and detects load-use hazards.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_srca_sel,
  input  logic [1:0]        id_srcb_sel,
  input  logic [3:0]        id_aluc,
  input  logic              id_reg_we,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              mem_reg_we,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_we,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [3:0]        ex_aluc,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall
);

  logic              valid_q, valid_d;
  logic              reg_we_q, reg_we_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [3:0]        aluc_q, aluc_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [15:0]       imm_q, imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic              srca_sel_q, srca_sel_d;
  logic [1:0]        srcb_sel_q, srcb_sel_d;

  logic              raw;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // Youngest producer wins; MEM loads are excluded because the load-use
  // stall guarantees the value has reached WB before it is consumed.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] addr,
                                            input logic [DATA_W-1:0] reg_val);
    if (addr == '0) begin
      return reg_val;
    end else if (mem_reg_we && !mem_is_load && (mem_rd_addr == addr)) begin
      return mem_result;
    end else if (wb_reg_we && (wb_rd_addr == addr)) begin
      return wb_data;
    end
    return reg_val;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    raw = id_valid & valid_q & mem_read_q & reg_we_q & (rd_q != '0) &
          ((id_uses_rs & (id_rs_addr == rd_q)) | (id_uses_rt & (id_rt_addr == rd_q)));
    stall = raw & ~flush;
  end

  // Next state: bubble on flush or load-use, otherwise capture ID with WB bypass.
  always_comb begin
    valid_d     = id_valid;
    reg_we_d    = id_valid & id_reg_we;
    mem_read_d  = id_valid & id_mem_read;
    mem_write_d = id_valid & id_mem_write;
    aluc_d      = id_aluc;
    rd_d        = id_rd_addr;
    rs_addr_d   = id_rs_addr;
    rt_addr_d   = id_rt_addr;
    rs_data_d   = (wb_reg_we && (wb_rd_addr != '0) && (wb_rd_addr == id_rs_addr)) ?
                  wb_data : id_rs_data;
    rt_data_d   = (wb_reg_we && (wb_rd_addr != '0) && (wb_rd_addr == id_rt_addr)) ?
                  wb_data : id_rt_data;
    imm_d       = id_imm;
    shamt_d     = id_shamt;
    srca_sel_d  = id_srca_sel;
    srcb_sel_d  = id_srcb_sel;
    if (flush || raw) begin
      valid_d     = 1'b0;
      reg_we_d    = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      aluc_d      = '0;
      rd_d        = '0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      shamt_d     = '0;
      srca_sel_d  = 1'b0;
      srcb_sel_d  = '0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      aluc_q      <= '0;
      rd_q        <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      srca_sel_q  <= 1'b0;
      srcb_sel_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_we_q    <= reg_we_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      aluc_q      <= aluc_d;
      rd_q        <= rd_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      srca_sel_q  <= srca_sel_d;
      srcb_sel_q  <= srcb_sel_d;
    end
  end

  // Forwarded operands and ALU source selection.
  always_comb begin
    fwd_rs = fwd(rs_addr_q, rs_data_q);
    fwd_rt = fwd(rt_addr_q, rt_data_q);
    ex_a   = srca_sel_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    case (srcb_sel_q)
      2'd0:    ex_b = fwd_rt;
      2'd1:    ex_b = {{(DATA_W-16){imm_q[15]}}, imm_q};
      2'd2:    ex_b = {{(DATA_W-16){1'b0}}, imm_q};
      default: ex_b = '0;
    endcase
    ex_store_data = fwd_rt;
    ex_valid      = valid_q;
    ex_reg_we     = reg_we_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_aluc       = aluc_q;
    ex_rd_addr    = rd_q;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic        id_srca_sel;
  logic [1:0]  id_srcb_sel;
  logic [3:0]  id_aluc;
  logic        id_reg_we, id_mem_read, id_mem_write;
  logic        mem_reg_we, mem_is_load;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_reg_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_aluc;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we, ex_mem_read, ex_mem_write, stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt),
    .id_srca_sel(id_srca_sel), .id_srcb_sel(id_srcb_sel), .id_aluc(id_aluc),
    .id_reg_we(id_reg_we), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_we(mem_reg_we), .mem_is_load(mem_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_we(wb_reg_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .stall(stall)
  );

  // Reference model: the instruction occupying EX, as a record.
  typedef struct {
    logic        valid, reg_we, is_load, is_store;
    logic [3:0]  op;
    logic [4:0]  dst, src1, src2;
    logic [31:0] val1, val2;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        a_is_shamt;
    logic [1:0]  b_kind;
  } instr_t;

  instr_t in_ex;

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: '0};
    return b;
  endfunction

  // Value a consumer of register r sees right now, newest writer first.
  function automatic logic [31:0] current_value(input logic [4:0] r, input logic [31:0] latched);
    if (r == 5'd0) return latched;
    if (mem_reg_we && !mem_is_load && mem_rd_addr == r) return mem_result;
    if (wb_reg_we && wb_rd_addr == r) return wb_data;
    return latched;
  endfunction

  function automatic logic exp_hazard();
    logic [4:0] d;
    d = in_ex.dst;
    if (!(id_valid && in_ex.valid && in_ex.is_load && in_ex.reg_we && d != 0)) return 1'b0;
    return (id_uses_rs && id_rs_addr == d) || (id_uses_rt && id_rt_addr == d);
  endfunction

  function automatic logic [31:0] exp_a();
    if (in_ex.a_is_shamt) return {27'd0, in_ex.shamt};
    return current_value(in_ex.src1, in_ex.val1);
  endfunction

  function automatic logic [31:0] exp_b();
    int signed simm;
    simm = int'($signed(in_ex.imm));
    if (in_ex.b_kind == 2'd0) return current_value(in_ex.src2, in_ex.val2);
    if (in_ex.b_kind == 2'd1) return 32'(simm);
    if (in_ex.b_kind == 2'd2) return 32'(in_ex.imm);
    return 32'd0;
  endfunction

  function automatic instr_t model_next();
    instr_t n;
    n = bubble();
    if (rst || flush || exp_hazard()) return n;
    n.valid      = id_valid;
    n.reg_we     = id_valid && id_reg_we;
    n.is_load    = id_valid && id_mem_read;
    n.is_store   = id_valid && id_mem_write;
    n.op         = id_aluc;
    n.dst        = id_rd_addr;
    n.src1       = id_rs_addr;
    n.src2       = id_rt_addr;
    // Register file write landing in the same cycle as the read.
    n.val1 = (wb_reg_we && wb_rd_addr != 0 && wb_rd_addr == id_rs_addr) ? wb_data : id_rs_data;
    n.val2 = (wb_reg_we && wb_rd_addr != 0 && wb_rd_addr == id_rt_addr) ? wb_data : id_rt_data;
    n.imm        = id_imm;
    n.shamt      = id_shamt;
    n.a_is_shamt = id_srca_sel;
    n.b_kind     = id_srcb_sel;
    return n;
  endfunction

  task automatic tick();
    instr_t n;
    n = model_next();
    @(posedge clk);
    in_ex = n;
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; flush = 0; id_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_srca_sel = 0; id_srcb_sel = 0; id_aluc = 0;
    id_reg_we = 0; id_mem_read = 0; id_mem_write = 0;
    mem_reg_we = 0; mem_is_load = 0; mem_rd_addr = 0; mem_result = 0;
    wb_reg_we = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  task automatic randomize_inputs();
    flush = ($urandom_range(0, 7) == 0);
    id_valid = $urandom_range(0, 3) != 0;
    id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
    id_rd_addr = 5'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = 16'($urandom); id_shamt = 5'($urandom);
    id_srca_sel = 1'($urandom); id_srcb_sel = 2'($urandom);
    id_aluc = 4'($urandom);
    id_reg_we = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom);
    mem_reg_we = 1'($urandom); mem_is_load = 1'($urandom);
    mem_rd_addr = 5'($urandom_range(0, 3)); mem_result = $urandom;
    wb_reg_we = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
  endtask

  task automatic test_reset();
    randomize_inputs();
    rst = 1;
    tick();
    randomize_inputs();
    rst = 1;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    n_checks++;
    if (ex_reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_reg_we got %0b want 0", ex_reg_we); end
    n_checks++;
    if (ex_a !== 32'd0) begin n_fail++; $display("FAIL reset_a got %h want 0", ex_a); end
    n_checks++;
    if (ex_b !== 32'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", ex_b); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
    clear_inputs();
    #1;
  endtask

  task automatic test_mem_wb_priority();
    clear_inputs();
    id_valid = 1; id_rs_addr = 3; id_uses_rs = 1; id_rs_data = 32'd5; id_rd_addr = 5'd5;
    id_reg_we = 1; id_aluc = 4'd2;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ex_a !== 32'd5) begin n_fail++; $display("FAIL prio_noforward got %h want 5", ex_a); end
    n_checks++;
    if ({ex_valid, ex_reg_we, ex_rd_addr, ex_aluc} !== {1'b1, 1'b1, 5'd5, 4'd2}) begin
      n_fail++;
      $display("FAIL prio_ctrl got %0b%0b rd=%0d op=%0d want 11 rd=5 op=2",
               ex_valid, ex_reg_we, ex_rd_addr, ex_aluc);
    end
    mem_reg_we = 1; mem_rd_addr = 3; mem_result = 32'h11;
    wb_reg_we = 1; wb_rd_addr = 3; wb_data = 32'h22;
    #1;
    n_checks++;
    if (ex_a !== 32'h11) begin n_fail++; $display("FAIL prio_mem got %h want 11", ex_a); end
    mem_reg_we = 0;
    #1;
    n_checks++;
    if (ex_a !== 32'h22) begin n_fail++; $display("FAIL prio_wb got %h want 22", ex_a); end
    mem_reg_we = 1; mem_is_load = 1;
    #1;
    n_checks++;
    if (ex_a !== 32'h22) begin n_fail++; $display("FAIL prio_memload got %h want 22", ex_a); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_we = 1; id_rd_addr = 4; id_rs_addr = 1; id_uses_rs = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_uses_rs = 1; id_rs_addr = 4; id_rd_addr = 6; id_reg_we = 1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall got %0b want 1", stall); end
    tick();
    mem_reg_we = 1; mem_is_load = 1; mem_rd_addr = 4; mem_result = 32'hBAD;
    #1;
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble got %0b want 0", ex_valid); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_onecycle got %0b want 0", stall); end
    tick();
    clear_inputs();
    wb_reg_we = 1; wb_rd_addr = 4; wb_data = 32'hDEAD;
    #1;
    n_checks++;
    if ({ex_valid, ex_rd_addr} !== {1'b1, 5'd6}) begin
      n_fail++; $display("FAIL loaduse_enter got v=%0b rd=%0d want v=1 rd=6", ex_valid, ex_rd_addr);
    end
    n_checks++;
    if (ex_a !== 32'hDEAD) begin n_fail++; $display("FAIL loaduse_fwd got %h want dead", ex_a); end
    clear_inputs();
  endtask

  task automatic test_flush();
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_we = 1; id_rd_addr = 4; id_rs_addr = 2; id_uses_rs = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_uses_rs = 1; id_rs_addr = 4; id_mem_write = 1; flush = 1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0b want 0", stall); end
    tick();
    n_checks++;
    if ({ex_valid, ex_mem_write, ex_reg_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_bubble got %0b%0b%0b want 000", ex_valid, ex_mem_write, ex_reg_we);
    end
    clear_inputs();
  endtask

  task automatic test_bypass_r0();
    clear_inputs();
    id_valid = 1; id_rs_addr = 7; id_uses_rs = 1; id_rs_data = 0;
    wb_reg_we = 1; wb_rd_addr = 7; wb_data = 32'h1234;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ex_a !== 32'h1234) begin n_fail++; $display("FAIL bypass_capture got %h want 1234", ex_a); end
    id_valid = 1; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 1; id_uses_rt = 1;
    mem_reg_we = 1; mem_rd_addr = 0; mem_result = 32'hFF;
    wb_reg_we = 1; wb_rd_addr = 0; wb_data = 32'hEE;
    tick();
    id_valid = 0;
    #1;
    n_checks++;
    if (ex_a !== 32'd0) begin n_fail++; $display("FAIL r0_a got %h want 0", ex_a); end
    n_checks++;
    if (ex_store_data !== 32'd0) begin n_fail++; $display("FAIL r0_store got %h want 0", ex_store_data); end
    clear_inputs();
  endtask

  task automatic test_imm_shift();
    logic [1:0]  sels [3];
    logic [31:0] want [3];
    sels = '{2'd1, 2'd2, 2'd3};
    want = '{32'hFFFF8001, 32'h00008001, 32'h0};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      id_valid = 1; id_imm = 16'h8001; id_srcb_sel = sels[i]; id_rt_addr = 2; id_rt_data = 32'h77;
      tick();
      n_checks++;
      if (ex_b !== want[i]) begin
        n_fail++; $display("FAIL imm_sel%0d got %h want %h", sels[i], ex_b, want[i]);
      end
      n_checks++;
      if (ex_store_data !== 32'h77) begin
        n_fail++; $display("FAIL imm_store%0d got %h want 77", sels[i], ex_store_data);
      end
    end
    clear_inputs();
    id_valid = 1; id_shamt = 31; id_srca_sel = 1; id_srcb_sel = 0;
    id_rt_addr = 9; id_uses_rt = 1; id_rt_data = 32'hA5A5; id_rs_addr = 1; id_rs_data = 32'h3;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ex_a !== 32'h1F) begin n_fail++; $display("FAIL sll_a got %h want 1f", ex_a); end
    n_checks++;
    if (ex_b !== 32'hA5A5) begin n_fail++; $display("FAIL sll_b got %h want a5a5", ex_b); end
    mem_reg_we = 1; mem_rd_addr = 9; mem_result = 32'hC0DE;
    #1;
    n_checks++;
    if (ex_b !== 32'hC0DE) begin n_fail++; $display("FAIL sll_bfwd got %h want c0de", ex_b); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, es;
    for (int cyc = 0; cyc < 400; cyc++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 39) == 0);
      #1;
      ea = exp_a();
      eb = exp_b();
      es = current_value(in_ex.src2, in_ex.val2);
      n_checks++;
      if (stall !== (exp_hazard() && !flush)) begin
        n_fail++; $display("FAIL rand_stall cyc=%0d got %0b want %0b", cyc, stall,
                           exp_hazard() && !flush);
      end
      n_checks++;
      if ({ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, ex_aluc, ex_rd_addr} !==
          {in_ex.valid, in_ex.reg_we, in_ex.is_load, in_ex.is_store, in_ex.op, in_ex.dst}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got %b%b%b%b op=%h rd=%0d want %b%b%b%b op=%h rd=%0d",
                 cyc, ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, ex_aluc, ex_rd_addr,
                 in_ex.valid, in_ex.reg_we, in_ex.is_load, in_ex.is_store, in_ex.op, in_ex.dst);
      end
      n_checks++;
      if (ex_a !== ea) begin n_fail++; $display("FAIL rand_a cyc=%0d got %h want %h", cyc, ex_a, ea); end
      n_checks++;
      if (ex_b !== eb) begin n_fail++; $display("FAIL rand_b cyc=%0d got %h want %h", cyc, ex_b, eb); end
      n_checks++;
      if (ex_store_data !== es) begin
        n_fail++; $display("FAIL rand_store cyc=%0d got %h want %h", cyc, ex_store_data, es);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    in_ex = bubble();
    clear_inputs();
    test_reset();
    test_mem_wb_priority();
    test_load_use();
    test_flush();
    test_bypass_r0();
    test_imm_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
